sram_bank: RTL and testbench

- Parametrised next-generation on-chip SRAM bank for the core's instruction and data memories.
- One write port and one read port, sharing a single clock.
- Adds the following over the current 8 KB array:
  - per-byte write strobes;
  - a registered, configurable-latency read pipeline with a valid flag;
  - defined read-during-write behaviour;
  - a post-reset clear sequencer that zeroes the array before accepting traffic.

---
 rtl/sram_pkg.sv | 21 ++
 rtl/sram_rd_pipe.sv | 44 ++++
 rtl/sram_bank.sv | 116 +++++++++++
 tb/tb_sram_bank.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM bank: FSM state encoding, strobe-width
// helper and the read-latency legality check used at elaboration time.
package sram_pkg;

  typedef enum logic [1:0] {
    CLEAR      = 2'd0,
    READY_WAIT = 2'd1,
    READY      = 2'd2
  } state_t;

  // Number of byte strobes for a given word width.
  function automatic int unsigned strb_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

  // Only one- and two-cycle read pipelines exist.
  function automatic bit rd_latency_ok(input int unsigned lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read pipeline: RD_LATENCY-deep data/valid shift register.
//   clk       rising-edge clock
//   flush     synchronous clear of all valid bits and data registers
//   in_valid  accepted read this cycle (loads stage 0)
//   in_data   array word to capture into stage 0
//   out_valid valid bit of the last stage
//   out_data  data of the last stage; holds its value between reads
module sram_rd_pipe
  import sram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [RD_LATENCY-1:0] vld_q;
  logic [DATA_WIDTH-1:0] data_q [RD_LATENCY];

  // Data registers load only alongside a valid bit so the output holds
  // the last returned word while no read is in flight.
  always_ff @(posedge clk) begin
    if (flush) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) data_q[i] <= '0;
    end else begin
      vld_q[0] <= in_valid;
      if (in_valid) data_q[0] <= in_data;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[RD_LATENCY-1];
  assign out_data  = data_q[RD_LATENCY-1];

endmodule

// File: rtl/sram_bank.sv
// Single-clock SRAM bank with one write port (byte strobes) and one read
// port (registered, RD_LATENCY-cycle pipeline), defined read-during-write
// behaviour and an optional post-reset clear sequencer.
//   clk, rst            clock, synchronous active-high reset
//   ready               bank accepts reads and writes
//   rd_en, rd_addr      read request / word address
//   rd_data, rd_valid   read result and its one-cycle valid flag
//   wr_en, wr_addr      write request / word address
//   wr_data, wr_strb    write word and per-byte enables
module sram_bank
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 11,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned RD_LATENCY     = 1,
  parameter bit          WRITE_FIRST    = 1'b1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic                             ready,
  input  logic                             rd_en,
  input  logic [ADDR_WIDTH-1:0]            rd_addr,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             rd_valid,
  input  logic                             wr_en,
  input  logic [ADDR_WIDTH-1:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic [strb_width(DATA_WIDTH)-1:0] wr_strb
);

  localparam int unsigned STRB_W = strb_width(DATA_WIDTH);
  localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CLR_LAST = {1'b0, {ADDR_WIDTH{1'b1}}};
  localparam state_t RST_STATE = CLEAR_ON_RESET ? CLEAR : READY_WAIT;

  if (!rd_latency_ok(RD_LATENCY)) begin : g_bad_latency
    $error("sram_bank: RD_LATENCY must be 1 or 2");
  end
  if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
    $error("sram_bank: DATA_WIDTH must be a multiple of 8");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state, state_d;
  logic [ADDR_WIDTH:0]   clr_cnt;
  logic                  wr_go, rd_go;
  logic [DATA_WIDTH-1:0] merged, rd_word;

  assign wr_go = ready & wr_en;
  assign rd_go = ready & rd_en;

  // State register and clear counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RST_STATE;
      clr_cnt <= '0;
    end else begin
      state <= state_d;
      if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      CLEAR:      if (clr_cnt == CLR_LAST) state_d = READY;
      READY_WAIT: state_d = READY;
      READY:      state_d = READY;
      default:    state_d = RST_STATE;
    endcase
  end

  // Output logic.
  always_comb begin
    ready = (state == READY);
  end

  // Array write: clear sequencer while clearing, strobed user write once
  // ready. The two never overlap because ready is low during CLEAR.
  always_ff @(posedge clk) begin
    if ((state == CLEAR) && !rst) begin
      mem[clr_cnt[ADDR_WIDTH-1:0]] <= '0;
    end else if (wr_go) begin
      for (int unsigned i = 0; i < STRB_W; i++) begin
        if (wr_strb[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Read word selection: a same-address write in write-first mode is
  // forwarded as the strobe-merged word; otherwise the prior contents.
  always_comb begin
    merged = mem[wr_addr];
    for (int unsigned i = 0; i < STRB_W; i++) begin
      if (wr_strb[i]) merged[8*i +: 8] = wr_data[8*i +: 8];
    end
    rd_word = mem[rd_addr];
    if (WRITE_FIRST && wr_go && (wr_addr == rd_addr)) rd_word = merged;
  end

  sram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_pipe (
    .clk       (clk),
    .flush     (rst),
    .in_valid  (rd_go),
    .in_data   (rd_word),
    .out_valid (rd_valid),
    .out_data  (rd_data)
  );

endmodule

// File: tb/tb_sram_bank.sv
// Directed bench for sram_bank. Three instances share stimulus:
//   a: latency 1, write-first, clear on reset
//   b: latency 2, read-first,  clear on reset
//   c: latency 1, write-first, no clear (own enables)
module tb_sram_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en, rd_en_c, wr_en_c;
  logic [3:0]  rd_addr, wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;

  logic        ready_a, ready_b, ready_c;
  logic        rd_valid_a, rd_valid_b, rd_valid_c;
  logic [31:0] rd_data_a, rd_data_b, rd_data_c;

  int n_checks = 0;
  int n_bad    = 0;

  always #5 clk = ~clk;

  sram_bank #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .RD_LATENCY(1),
              .WRITE_FIRST(1'b1), .CLEAR_ON_RESET(1'b1)) dut_a (
    .clk(clk), .rst(rst), .ready(ready_a),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb));

  sram_bank #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .RD_LATENCY(2),
              .WRITE_FIRST(1'b0), .CLEAR_ON_RESET(1'b1)) dut_b (
    .clk(clk), .rst(rst), .ready(ready_b),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb));

  sram_bank #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .RD_LATENCY(1),
              .WRITE_FIRST(1'b1), .CLEAR_ON_RESET(1'b0)) dut_c (
    .clk(clk), .rst(rst), .ready(ready_c),
    .rd_en(rd_en_c), .rd_addr(rd_addr), .rd_data(rd_data_c), .rd_valid(rd_valid_c),
    .wr_en(wr_en_c), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; rd_en_c = 1'b0; wr_en_c = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_data = '0; wr_strb = '0;
    tick(); tick();

    // Reset state
    check_eq("rst_ready_a", ready_a, 0);
    check_eq("rst_ready_b", ready_b, 0);
    check_eq("rst_ready_c", ready_c, 0);
    check_eq("rst_vld_a", rd_valid_a, 0);
    check_eq("rst_vld_b", rd_valid_b, 0);
    check_eq("rst_data_a", rd_data_a, 0);
    check_eq("rst_data_b", rd_data_b, 0);

    // Clear sequence with requests pulsed during it (must be ignored)
    rst = 1'b0;
    rd_en = 1'b1; rd_addr = 4'd3;
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hFFFF_FFFF; wr_strb = 4'hF;
    for (int n = 1; n <= 16; n++) begin
      tick();
      if (n == 10) begin rd_en = 1'b0; wr_en = 1'b0; end
      check_eq("clr_vld_a", rd_valid_a, 0);
      check_eq("clr_vld_b", rd_valid_b, 0);
      check_eq("clr_ready_a", ready_a, (n == 16) ? 1 : 0);
      check_eq("clr_ready_b", ready_b, (n == 16) ? 1 : 0);
      check_eq("wait_ready_c", ready_c, (n >= 1) ? 1 : 0);
      check_eq("wait_vld_c", rd_valid_c, 0);
    end

    // Every word reads zero after the clear, back-to-back
    for (int a = 0; a < 16; a++) begin
      rd_en = 1'b1; rd_addr = 4'(a);
      tick();
      check_eq("clr_rd_vld_a", rd_valid_a, 1);
      check_eq("clr_rd_data_a", rd_data_a, 0);
      if (a > 0) begin
        check_eq("clr_rd_vld_b", rd_valid_b, 1);
        check_eq("clr_rd_data_b", rd_data_b, 0);
      end
    end
    rd_en = 1'b0;
    tick();
    check_eq("clr_rd_end_a", rd_valid_a, 0);
    check_eq("clr_rd_last_b", rd_valid_b, 1);
    tick();
    check_eq("clr_rd_end_b", rd_valid_b, 0);

    // Byte strobes
    wr(4'd5, 32'hAABB_CCDD, 4'hF);
    wr(4'd5, 32'h1122_3344, 4'b0101);
    rd_en = 1'b1; rd_addr = 4'd5;
    tick();
    rd_en = 1'b0;
    check_eq("strb_vld_a", rd_valid_a, 1);
    check_eq("strb_data_a", rd_data_a, 32'hAA22_CC44);
    check_eq("strb_vld_b_early", rd_valid_b, 0);
    tick();
    check_eq("strb_vld_a_once", rd_valid_a, 0);
    check_eq("strb_vld_b", rd_valid_b, 1);
    check_eq("strb_data_b", rd_data_b, 32'hAA22_CC44);

    // Zero strobe is a no-op
    wr(4'd5, 32'h0000_0000, 4'h0);
    rd_en = 1'b1; rd_addr = 4'd5;
    tick();
    rd_en = 1'b0;
    check_eq("strb0_data_a", rd_data_a, 32'hAA22_CC44);
    tick();
    check_eq("strb0_data_b", rd_data_b, 32'hAA22_CC44);

    // Pipelined reads
    wr(4'd1, 32'h1, 4'hF);
    wr(4'd2, 32'h2, 4'hF);
    wr(4'd3, 32'h3, 4'hF);
    for (int i = 1; i <= 3; i++) begin
      rd_en = 1'b1; rd_addr = 4'(i);
      tick();
      check_eq("pipe_vld_a", rd_valid_a, 1);
      check_eq("pipe_data_a", rd_data_a, 32'(i));
      check_eq("pipe_vld_b", rd_valid_b, (i >= 2) ? 1 : 0);
      if (i >= 2) check_eq("pipe_data_b", rd_data_b, 32'(i - 1));
    end
    rd_en = 1'b0;
    tick();
    check_eq("pipe_end_a", rd_valid_a, 0);
    check_eq("pipe_vld3_b", rd_valid_b, 1);
    check_eq("pipe_data3_b", rd_data_b, 32'h3);
    tick();
    check_eq("pipe_end_b", rd_valid_b, 0);
    check_eq("pipe_hold_b", rd_data_b, 32'h3);

    // Read during write to the same address
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'hDEAD_BEEF; wr_strb = 4'b0011;
    rd_en = 1'b1; rd_addr = 4'd7;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check_eq("rdw_vld_a", rd_valid_a, 1);
    check_eq("rdw_wf_a", rd_data_a, 32'h0000_BEEF);
    tick();
    check_eq("rdw_vld_b", rd_valid_b, 1);
    check_eq("rdw_rf_b", rd_data_b, 32'h0000_0000);
    rd_en = 1'b1; rd_addr = 4'd7;
    tick();
    rd_en = 1'b0;
    check_eq("rdw_after_a", rd_data_a, 32'h0000_BEEF);
    tick();
    check_eq("rdw_after_b", rd_data_b, 32'h0000_BEEF);

    // Read and write to different addresses do not interact
    wr_en = 1'b1; wr_addr = 4'd8; wr_data = 32'h1234_5678; wr_strb = 4'hF;
    rd_en = 1'b1; rd_addr = 4'd5;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check_eq("diff_data_a", rd_data_a, 32'hAA22_CC44);
    tick();
    check_eq("diff_data_b", rd_data_b, 32'hAA22_CC44);
    rd_en = 1'b1; rd_addr = 4'd8;
    tick();
    rd_en = 1'b0;
    check_eq("diff_wr_a", rd_data_a, 32'h1234_5678);
    tick();

    // Instance without clear: plain write then read
    wr_en_c = 1'b1; wr_addr = 4'd2; wr_data = 32'hCAFE_F00D; wr_strb = 4'hF;
    tick();
    wr_en_c = 1'b0;
    rd_en_c = 1'b1; rd_addr = 4'd2;
    tick();
    rd_en_c = 1'b0;
    check_eq("c_vld", rd_valid_c, 1);
    check_eq("c_data", rd_data_c, 32'hCAFE_F00D);
    tick();
    check_eq("c_vld_once", rd_valid_c, 0);
    check_eq("c_hold", rd_data_c, 32'hCAFE_F00D);

    // Mid-clear reset, with an in-flight read on the two-stage pipe
    wr(4'd9,  32'h9999_9999, 4'hF);
    wr(4'd10, 32'hA0A0_A0A0, 4'hF);
    wr(4'd15, 32'hFFFF_0000, 4'hF);
    rd_en = 1'b1; rd_addr = 4'd10;
    tick();
    rd_en = 1'b0;
    check_eq("kill_pre_a", rd_data_a, 32'hA0A0_A0A0);
    check_eq("kill_pre_b", rd_valid_b, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("kill_vld_b", rd_valid_b, 0);
    check_eq("kill_data_b", rd_data_b, 0);
    check_eq("kill_data_a", rd_data_a, 0);
    check_eq("kill_ready_a", ready_a, 0);
    for (int n = 1; n <= 9; n++) begin
      tick();
      check_eq("mid_ready_a", ready_a, 0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rerst_ready_a", ready_a, 0);
    for (int n = 1; n <= 16; n++) begin
      tick();
      check_eq("reclr_ready_a", ready_a, (n == 16) ? 1 : 0);
      check_eq("reclr_ready_b", ready_b, (n == 16) ? 1 : 0);
    end
    rd_en = 1'b1; rd_addr = 4'd9;
    tick();
    check_eq("reclr_9", rd_data_a, 0);
    rd_addr = 4'd10;
    tick();
    check_eq("reclr_10", rd_data_a, 0);
    rd_addr = 4'd15;
    tick();
    rd_en = 1'b0;
    check_eq("reclr_15_vld", rd_valid_a, 1);
    check_eq("reclr_15", rd_data_a, 0);
    tick();
    check_eq("reclr_15_b", rd_data_b, 0);
    check_eq("reclr_15_vld_b", rd_valid_b, 1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
